pc_gen_btb: RTL and testbench
=============================

PC_GEN_BTB -- requirements
Module: pc_gen_btb

Interface
REQ-001 Parameter PC_W, default 32, meaning PC and target width in bits; legal range 28 or more.
REQ-002 Parameter BTB_DEPTH, default 16, meaning number of branch-target-buffer entries; must be a power of two and at least 2; IDX_W = log2(BTB_DEPTH).
REQ-003 Parameter RESET_VECTOR, default 0, meaning PC value loaded on reset.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 reset  input  1  reset is synchronous and active-high.
REQ-006 pcwrite  input  1  0 holds PC (hazard stall).
REQ-007 jump  input  1  J-type instruction in fetch/decode.
REQ-008 instr_code  input  32  instruction word; bits [25:0] hold the jump index.
REQ-009 resolve_valid  input  1  one-cycle pulse: a branch resolved in EX/MEM.
REQ-010 resolve_pc  input  PC_W  address of the resolved branch.
REQ-011 resolve_taken  input  1  actual branch outcome.
REQ-012 resolve_target  input  PC_W  computed branch target.
REQ-013 resolve_pred_taken  input  1  prediction that was carried down the pipe with the branch.
REQ-014 PC  output  PC_W  current fetch address, registered.
REQ-015 pred_taken  output  1  combinational prediction for the current PC; pipelined downstream by the instantiator.
REQ-016 mispredict  output  1  combinational flush request to IF/ID and ID/EX.

Function
REQ-017 Each BTB entry SHALL hold: valid, tag = addr[PC_W-1:2+IDX_W], target[PC_W-1:0], and a 2-bit saturating counter ctr.
REQ-018 The BTB index SHALL be addr[2+IDX_W-1:2].
REQ-019 hit SHALL equal entry[PC index].valid AND tag match; pred_taken SHALL equal hit AND ctr[1].
REQ-020 mispredict SHALL equal resolve_valid AND (resolve_taken XOR resolve_pred_taken).
REQ-021 Next-PC priority, highest first:
 - reset -> RESET_VECTOR
 - mispredict -> resolve_taken ? resolve_target : resolve_pc+4
 - pcwrite=0 -> hold PC
 - jump -> zero-extend({instr_code[25:0],2'b00}) to PC_W, upper bits zero
 - pred_taken -> entry target
 - otherwise PC+4
REQ-022 All PC arithmetic SHALL be modulo 2^PC_W; all-ones-minus-3 plus 4 wraps to 0.
REQ-023 Latency: a redirect, jump or prediction SHALL appear on PC exactly one clock edge after the cycle in which it is asserted.
REQ-024 On resolve_valid with a hit at resolve_pc:
 - ctr increments on taken, saturating at 3
 - ctr decrements on not-taken, saturating at 0
 - target is overwritten with resolve_target on taken
REQ-025 On resolve_valid with a miss and taken, the entry SHALL be allocated: valid=1, new tag, target=resolve_target, ctr=2'b10. This replaces any aliasing entry.
REQ-026 On resolve_valid with a miss and not-taken, no BTB state SHALL change.
REQ-027 BTB update SHALL occur on resolve_valid regardless of pcwrite, jump or mispredict.
REQ-028 When a BTB update and a lookup use the same index in the same cycle, the lookup SHALL see the pre-update contents; there is no bypass.
REQ-029 No X SHALL propagate from unwritten entries; valid=0 forces hit=0.

Reset
REQ-030 While reset=1 at a rising edge:
 - PC = RESET_VECTOR
 - all valid bits = 0
 - all ctr = 2'b01
 - BTB updates are suppressed
REQ-031 Target and tag storage need not be reset.
REQ-032 Reset asserted mid-operation SHALL override every other input in that cycle.
REQ-033 With valid=0 everywhere after reset, pred_taken=0.

Verification
REQ-034 Reset 2 cycles, then release with pcwrite=1 -> PC = 0x0, 0x4, 0x8, 0xC; pred_taken=0 throughout.
REQ-035 At PC=0x10, pcwrite=0 for 3 cycles -> PC stays 0x10, then 0x14 after pcwrite=1; jump with instr_code[25:0]=0x40 -> next PC 0x100.
REQ-036 Resolve at 0x20: taken, target 0x80, pred 0 -> mispredict=1 and next PC 0x80; when PC later reaches 0x20 -> pred_taken=1 and next PC 0x80.
REQ-037 Same branch resolved not-taken with pred 1 -> mispredict=1 and next PC 0x24; ctr goes from 10 to 01; next fetch of 0x20 -> pred_taken=0.
REQ-038 Aliasing, default depth: 0x60 resolves taken -> it replaces the 0x20 entry; fetch at 0x20 -> miss, pred_taken=0.
REQ-039 mispredict, pcwrite=0 and jump asserted together -> redirect target wins.
REQ-040 PC=0xFFFFFFFC with no event -> next PC 0x0.
REQ-041 Reset asserted alongside resolve_valid -> PC=RESET_VECTOR and no entry allocated.

Source files
------------

// File: rtl/pc_gen_btb.sv
// Fetch PC generator with a direct-mapped branch target buffer and 2-bit counters.
// BTB is trained by branches resolved in EX/MEM; the resolve port also redirects fetch on a mispredict.
module pc_gen_btb #(
    parameter int              PC_W         = 32,
    parameter int              BTB_DEPTH    = 16,
    parameter logic [PC_W-1:0] RESET_VECTOR = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pcwrite,
    input  logic            jump,
    input  logic [31:0]     instr_code,
    input  logic            resolve_valid,
    input  logic [PC_W-1:0] resolve_pc,
    input  logic            resolve_taken,
    input  logic [PC_W-1:0] resolve_target,
    input  logic            resolve_pred_taken,
    output logic [PC_W-1:0] PC,
    output logic            pred_taken,
    output logic            mispredict
);

    localparam int IDX_W = $clog2(BTB_DEPTH);
    localparam int TAG_W = PC_W - 2 - IDX_W;

    logic [PC_W-1:0]  r_pc;
    logic [BTB_DEPTH-1:0] r_valid;
    logic [1:0]       r_ctr    [BTB_DEPTH];
    logic [TAG_W-1:0] r_tag    [BTB_DEPTH];
    logic [PC_W-1:0]  r_target [BTB_DEPTH];

    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_tag;
    logic             w_hit;
    logic [IDX_W-1:0] w_ridx;
    logic [TAG_W-1:0] w_rtag;
    logic             w_rhit;
    logic [PC_W-1:0]  w_jump_pc;
    logic [PC_W-1:0]  w_next_pc;
    logic             w_unused;

    // Fetch-side lookup reads the array as it stood before this edge's update.
    assign w_idx  = r_pc[2+IDX_W-1:2];
    assign w_tag  = r_pc[PC_W-1:2+IDX_W];
    assign w_hit  = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

    assign w_ridx = resolve_pc[2+IDX_W-1:2];
    assign w_rtag = resolve_pc[PC_W-1:2+IDX_W];
    assign w_rhit = r_valid[w_ridx] && (r_tag[w_ridx] == w_rtag);

    assign w_jump_pc  = PC_W'({instr_code[25:0], 2'b00});
    assign w_unused   = ^instr_code[31:26];

    assign pred_taken = w_hit && r_ctr[w_idx][1];
    assign mispredict = resolve_valid && (resolve_taken ^ resolve_pred_taken);
    assign PC         = r_pc;

    always_comb begin
        // NOTE: default assigned first so every path drives w_next_pc and no latch is inferred.
        w_next_pc = r_pc + PC_W'(4);
        if (mispredict)
            w_next_pc = resolve_taken ? resolve_target : resolve_pc + PC_W'(4);
        else if (!pcwrite)
            w_next_pc = r_pc;
        else if (jump)
            w_next_pc = w_jump_pc;
        else if (pred_taken)
            w_next_pc = r_target[w_idx];
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset)
            r_pc <= RESET_VECTOR;
        else
            r_pc <= w_next_pc;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
            for (int i = 0; i < BTB_DEPTH; i++)
                r_ctr[i] <= 2'b01;
        end else if (resolve_valid) begin
            if (w_rhit) begin
                if (resolve_taken && r_ctr[w_ridx] != 2'b11)
                    r_ctr[w_ridx] <= r_ctr[w_ridx] + 2'd1;
                else if (!resolve_taken && r_ctr[w_ridx] != 2'b00)
                    r_ctr[w_ridx] <= r_ctr[w_ridx] - 2'd1;
            end else if (resolve_taken) begin
                r_valid[w_ridx] <= 1'b1;
                r_ctr[w_ridx]   <= 2'b10;
            end
        end
    end

    // NOTE: tag/target storage is left unreset; valid gates every use of it.
    always_ff @(posedge clk) begin
        if (!reset && resolve_valid && resolve_taken) begin
            r_tag[w_ridx]    <= w_rtag;
            r_target[w_ridx] <= resolve_target;
        end
    end

endmodule

// File: tb/tb_pc_gen_btb.sv
// Self-checking bench for pc_gen_btb: directed vector table, hand sequences,
// then randomized traffic checked against a map-based BTB model.
module tb_pc_gen_btb;

    logic        clk = 1'b0;
    logic        reset, pcwrite, jump;
    logic [31:0] instr_code;
    logic        resolve_valid, resolve_taken, resolve_pred_taken;
    logic [31:0] resolve_pc, resolve_target;
    logic [31:0] PC;
    logic        pred_taken, mispredict;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pc_gen_btb dut (
        .clk                (clk),
        .reset              (reset),
        .pcwrite            (pcwrite),
        .jump               (jump),
        .instr_code         (instr_code),
        .resolve_valid      (resolve_valid),
        .resolve_pc         (resolve_pc),
        .resolve_taken      (resolve_taken),
        .resolve_target     (resolve_target),
        .resolve_pred_taken (resolve_pred_taken),
        .PC                 (PC),
        .pred_taken         (pred_taken),
        .mispredict         (mispredict)
    );

    typedef struct {
        bit        rst, pw, jmp;
        bit [31:0] ic;
        bit        rv;
        bit [31:0] rpc;
        bit        rtk;
        bit [31:0] rtgt;
        bit        rpt;
        bit        e_pred, e_mis;
        bit [31:0] e_pc;
    } vec_t;

    function automatic vec_t mk(bit rst, bit pw, bit jmp, bit [31:0] ic, bit rv,
                                bit [31:0] rpc, bit rtk, bit [31:0] rtgt, bit rpt,
                                bit e_pred, bit e_mis, bit [31:0] e_pc);
        vec_t v;
        v.rst = rst; v.pw = pw; v.jmp = jmp; v.ic = ic; v.rv = rv; v.rpc = rpc;
        v.rtk = rtk; v.rtgt = rtgt; v.rpt = rpt;
        v.e_pred = e_pred; v.e_mis = e_mis; v.e_pc = e_pc;
        return v;
    endfunction

    function automatic vec_t idle(bit e_pred, bit [31:0] e_pc);
        return mk(0, 1, 0, 0, 0, 0, 0, 0, 0, e_pred, 0, e_pc);
    endfunction

    function automatic vec_t jmp_to(bit [31:0] ic, bit e_pred, bit [31:0] e_pc);
        return mk(0, 1, 1, ic, 0, 0, 0, 0, 0, e_pred, 0, e_pc);
    endfunction

    function automatic vec_t res(bit [31:0] rpc, bit rtk, bit [31:0] rtgt, bit rpt,
                                 bit e_pred, bit e_mis, bit [31:0] e_pc);
        return mk(0, 1, 0, 0, 1, rpc, rtk, rtgt, rpt, e_pred, e_mis, e_pc);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(vec_t v, bit chk_comb, string tag);
        @(negedge clk);
        reset = v.rst; pcwrite = v.pw; jump = v.jmp; instr_code = v.ic;
        resolve_valid = v.rv; resolve_pc = v.rpc; resolve_taken = v.rtk;
        resolve_target = v.rtgt; resolve_pred_taken = v.rpt;
        #1;
        if (chk_comb) begin
            check({tag, " pred_taken"}, 32'(pred_taken), 32'(v.e_pred));
            check({tag, " mispredict"}, 32'(mispredict), 32'(v.e_mis));
        end
        @(posedge clk);
        #1;
        check({tag, " PC"}, PC, v.e_pc);
    endtask

    // Behavioural model: each index remembers which word address owns it.
    typedef struct { bit [29:0] word; bit [31:0] tgt; bit [1:0] ctr; } ent_t;
    ent_t      m_btb[int];
    bit [31:0] m_pc;

    function automatic int m_idx(bit [31:0] a);
        return int'((a >> 2) % 16);
    endfunction

    function automatic bit m_hit(bit [31:0] a);
        return m_btb.exists(m_idx(a)) && m_btb[m_idx(a)].word == a[31:2];
    endfunction

    task automatic model_step(inout vec_t v);
        int i;
        v.e_mis  = v.rv && (v.rtk != v.rpt);
        v.e_pred = m_hit(m_pc) && m_btb[m_idx(m_pc)].ctr >= 2;
        if (v.rst)         v.e_pc = 32'h0;
        else if (v.e_mis)  v.e_pc = v.rtk ? v.rtgt : v.rpc + 32'd4;
        else if (!v.pw)    v.e_pc = m_pc;
        else if (v.jmp)    v.e_pc = {4'b0, v.ic[25:0], 2'b00};
        else if (v.e_pred) v.e_pc = m_btb[m_idx(m_pc)].tgt;
        else               v.e_pc = m_pc + 32'd4;
        if (v.rst) begin
            m_btb.delete();
        end else if (v.rv) begin
            i = m_idx(v.rpc);
            if (m_hit(v.rpc)) begin
                if (v.rtk) begin
                    m_btb[i].ctr = (m_btb[i].ctr == 3) ? 2'd3 : m_btb[i].ctr + 2'd1;
                    m_btb[i].tgt = v.rtgt;
                end else begin
                    m_btb[i].ctr = (m_btb[i].ctr == 0) ? 2'd0 : m_btb[i].ctr - 2'd1;
                end
            end else if (v.rtk) begin
                m_btb[i] = '{word: v.rpc[31:2], tgt: v.rtgt, ctr: 2'd2};
            end
        end
        m_pc = v.e_pc;
    endtask

    vec_t tbl[$];
    vec_t seq[$];

    initial begin
        vec_t v;
        reset = 1; pcwrite = 1; jump = 0; instr_code = 0; resolve_valid = 0;
        resolve_pc = 0; resolve_taken = 0; resolve_target = 0; resolve_pred_taken = 0;

        apply(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0), 0, "rst0");
        apply(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0), 1, "rst1");

        // Sequential PC, stall, jump, training, aliasing, redirect priority.
        tbl.push_back(idle(0, 32'h4));
        tbl.push_back(idle(0, 32'h8));
        tbl.push_back(idle(0, 32'hC));
        tbl.push_back(idle(0, 32'h10));
        for (int k = 0; k < 3; k++)
            tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h10));
        tbl.push_back(idle(0, 32'h14));
        tbl.push_back(jmp_to(32'h40, 0, 32'h100));
        tbl.push_back(res(32'h20, 1, 32'h80, 0, 0, 1, 32'h80));
        tbl.push_back(jmp_to(32'h08, 0, 32'h20));
        tbl.push_back(idle(1, 32'h80));
        tbl.push_back(res(32'h20, 0, 32'h80, 1, 0, 1, 32'h24));
        tbl.push_back(jmp_to(32'h08, 0, 32'h20));
        tbl.push_back(idle(0, 32'h24));
        tbl.push_back(res(32'h60, 1, 32'h40, 0, 0, 1, 32'h40));
        tbl.push_back(jmp_to(32'h08, 0, 32'h20));
        tbl.push_back(idle(0, 32'h24));
        tbl.push_back(jmp_to(32'h18, 0, 32'h60));
        tbl.push_back(idle(1, 32'h40));
        tbl.push_back(mk(0, 0, 1, 32'h40, 1, 32'h30, 0, 32'h0, 1, 0, 1, 32'h34));
        tbl.push_back(jmp_to(32'h0C, 0, 32'h30));
        tbl.push_back(idle(0, 32'h34));
        foreach (tbl[k]) apply(tbl[k], 1, $sformatf("tbl%0d", k));

        // Wrap-around, same-cycle update/lookup, counter saturation, reset override.
        seq.push_back(res(32'hFFFF_FFF8, 0, 32'h0, 1, 0, 1, 32'hFFFF_FFFC));
        seq.push_back(idle(0, 32'h0));
        seq.push_back(res(32'h0, 1, 32'h300, 1, 0, 0, 32'h4));
        seq.push_back(jmp_to(32'h0, 0, 32'h0));
        seq.push_back(idle(1, 32'h300));
        seq.push_back(res(32'h0, 1, 32'h300, 1, 0, 0, 32'h304));
        seq.push_back(res(32'h0, 1, 32'h300, 1, 0, 0, 32'h308));
        seq.push_back(res(32'h0, 0, 32'h0, 0, 0, 0, 32'h30C));
        seq.push_back(jmp_to(32'h0, 0, 32'h0));
        seq.push_back(idle(1, 32'h300));
        seq.push_back(res(32'h0, 0, 32'h0, 0, 0, 0, 32'h304));
        seq.push_back(jmp_to(32'h0, 0, 32'h0));
        seq.push_back(idle(0, 32'h4));
        seq.push_back(res(32'h0, 0, 32'h0, 0, 0, 0, 32'h8));
        seq.push_back(res(32'h0, 0, 32'h0, 0, 0, 0, 32'hC));
        seq.push_back(res(32'h0, 1, 32'h300, 1, 0, 0, 32'h10));
        seq.push_back(jmp_to(32'h0, 0, 32'h0));
        seq.push_back(idle(0, 32'h4));
        foreach (seq[k]) apply(seq[k], 1, $sformatf("seq%0d", k));
        apply(mk(1, 0, 1, 32'h55, 1, 32'h40, 1, 32'h700, 0, 0, 0, 32'h0), 0, "rst_res");
        apply(idle(0, 32'h4), 1, "post_rst0");
        apply(jmp_to(32'h10, 0, 32'h40), 1, "post_rst1");
        apply(idle(0, 32'h44), 1, "post_rst2");

        // Randomized traffic against the model; first cycle resets to sync it.
        v = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_step(v);
        apply(v, 0, "rnd_sync");
        for (int c = 0; c < 3000; c++) begin
            v.rst  = ($urandom_range(0, 199) == 0);
            v.pw   = ($urandom_range(0, 9) != 0);
            v.jmp  = ($urandom_range(0, 11) == 0);
            v.ic   = {6'($urandom), 20'h0, 6'($urandom_range(0, 63))};
            v.rv   = ($urandom_range(0, 2) == 0);
            v.rpc  = ($urandom_range(0, 1) == 0) ? m_pc : 32'($urandom_range(0, 63)) * 4;
            v.rtk  = 1'($urandom);
            v.rtgt = 32'($urandom_range(0, 63)) * 4;
            v.rpt  = ($urandom_range(0, 3) == 0) ? ~v.rtk : v.rtk;
            model_step(v);
            apply(v, 1, $sformatf("rnd%0d", c));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
